opcode_sequencer: RTL and testbench
===================================

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter OPC_LSB, default 5, meaning the LSB position of the 3-bit opcode field, which occupies IR_IN[OPC_LSB+2:OPC_LSB].
REQ-003 The block SHALL have parameter EXEC_CYCLES, default 4, legal range 1..8, meaning the number of cycles EN is held per instruction.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port IR_IN, input, DATA_W bits: instruction word.
REQ-007 The block SHALL have port IR_VALID, input, 1 bit: IR_IN holds a valid instruction.
REQ-008 The block SHALL have port IR_READY, output, 1 bit: the sequencer accepts an instruction this cycle.
REQ-009 The block SHALL have port S, output, 3 bits: opcode select driven to the downstream 3-to-8 decoder.
REQ-010 The block SHALL have port EN, output, 1 bit: decoder enable.
REQ-011 The block SHALL have port BUSY, output, 1 bit: an instruction is in LOAD or EXEC.
REQ-012 The block SHALL have port DONE, output, 1 bit: one-cycle pulse on instruction completion.
REQ-013 The block SHALL have port HALTED, output, 1 bit: a halt opcode has been executed.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, EXEC and HALT.
REQ-015 In IDLE, IR_READY SHALL be 1; in all other states it SHALL be 0.
REQ-016 A handshake SHALL occur on a rising edge with IR_VALID=1 and IR_READY=1; at that edge the opcode field SHALL be captured into S and the state SHALL go to LOAD.
REQ-017 With IR_VALID=0 in IDLE, the state, S and EN SHALL be unchanged.
REQ-018 LOAD SHALL last exactly 1 cycle, with EN=0 and S stable (select settle), then go to EXEC unless the opcode is 3'b111.
REQ-019 In EXEC, EN SHALL be 1 for exactly EXEC_CYCLES consecutive cycles, counted by a down-counter loaded with EXEC_CYCLES-1 on LOAD->EXEC; at count 0 the state SHALL go to IDLE.
REQ-020 DONE SHALL be 1 for exactly the first IDLE cycle after EXEC, and 0 otherwise.
REQ-021 S SHALL hold the last captured opcode until the next handshake; S SHALL never change while EN=1.
REQ-022 Opcode 3'b111 SHALL be HALT: LOAD goes to HALT, EN is never asserted for it, DONE is not pulsed, HALTED=1, and HALT is left only by RST.
REQ-023 BUSY SHALL be 1 in LOAD and EXEC, and 0 in IDLE and HALT.
REQ-024 Minimum instruction spacing SHALL be EXEC_CYCLES+2 cycles, i.e. 6 at default; IR_VALID held high SHALL be accepted on the DONE cycle.
REQ-025 IR_IN bits outside the opcode field SHALL be ignored.

Reset
REQ-026 While RST=1 at a rising edge, the block SHALL set state=IDLE, S=3'b000, EN=0, DONE=0, BUSY=0, HALTED=0, counter=0; IR_READY SHALL be 0 during any cycle in which RST=1.
REQ-027 RST SHALL take priority over a simultaneous handshake, which is discarded.
REQ-028 RST asserted mid-EXEC SHALL drop EN at that same edge; no DONE pulse SHALL follow.

Structure
REQ-029 Package cpu_ctrl_pkg SHALL hold the FSM state enum, OPC_W=3 and HALT_OPC=3'b111.
REQ-030 The EXEC countdown SHALL be a single sub-module exec_timer (load, decrement, zero flag); all other logic SHALL be in opcode_sequencer.

Verification
REQ-031 Reset: RST=1 for 2 cycles, then 0 -> S=000, EN=0, DONE=0, IR_READY=1 on the first post-reset cycle.
REQ-032 Single instruction: IR_IN=8'b010_00000 with IR_VALID for 1 cycle -> S=010 from the next cycle, EN=1 in cycles +2..+5, DONE=1 at +6.
REQ-033 Back-to-back: IR_VALID held high with 0x20 then 0xC0 -> S goes 001 then 110, second EN window starts 6 cycles after the first, S stable throughout each EN window.
REQ-034 Halt: IR_IN=0xE0 -> HALTED=1 from cycle +2, EN stays 0, IR_READY stays 0, and a later IR_VALID is ignored until RST.
REQ-035 Reset mid-EXEC: RST in the 2nd EN cycle -> EN=0 on the next cycle, no DONE pulse, S=000.
REQ-036 Parameter sweep: with EXEC_CYCLES=1 and 8 -> EN width equals 1 and 8 cycles respectively.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared opcode constants and sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int OPC_W = 3;
    localparam logic [OPC_W-1:0] HALT_OPC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/exec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_timer
//  Description : Loadable down-counter with zero flag timing the EXEC phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Saturates at zero so a stray decrement can never wrap the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : exec_timer
`default_nettype wire

// File: rtl/opcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_sequencer
//  Description : Fetches an opcode, settles the decoder select, then enables
//                the downstream 3-to-8 decoder for a fixed number of cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module opcode_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OPC_LSB     = 5,
    parameter int EXEC_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IR_IN,
    input  logic              IR_VALID,
    output logic              IR_READY,
    output logic [OPC_W-1:0]  S,
    output logic              EN,
    output logic              BUSY,
    output logic              DONE,
    output logic              HALTED
);

    localparam int c_CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(EXEC_CYCLES - 1);

    seq_state_t       r_state;
    logic [OPC_W-1:0] r_s;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic             r_halted;

    logic [OPC_W-1:0] w_opc;
    logic             w_timer_load;
    logic             w_timer_dec;
    logic             w_timer_zero;
    logic             w_unused_ir;

    assign w_opc       = IR_IN[OPC_LSB +: OPC_W];
    assign w_unused_ir = ^IR_IN;

    // Combinational so a reset cycle never advertises readiness.
    assign IR_READY = (r_state == ST_IDLE) && !RST;

    assign w_timer_load = (r_state == ST_LOAD) && (r_s != HALT_OPC);
    assign w_timer_dec  = (r_state == ST_EXEC);

    exec_timer #(
        .CNT_W (c_CNT_W)
    ) u_exec_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_timer_load),
        .i_load_val (c_LOAD_VAL),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_s      <= '0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (IR_VALID) begin
                        r_s     <= w_opc;
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_s == HALT_OPC) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                        r_en    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_timer_zero) begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S      = r_s;
    assign EN     = r_en;
    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign HALTED = r_halted;

endmodule : opcode_sequencer
`default_nettype wire

// File: tb/tb_opcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opcode_sequencer
//  Description : Three sequencers (EXEC_CYCLES 4/1/8) against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opcode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ir_valid;
    logic [7:0] ir_in;

    logic [2:0] ready, en, busy, done, halted;
    logic [2:0] s_o [3];

    always #5 clk = ~clk;

    opcode_sequencer #(.DATA_W(8), .OPC_LSB(5), .EXEC_CYCLES(4)) u_dut4 (
        .CLK(clk), .RST(rst), .IR_IN(ir_in), .IR_VALID(ir_valid),
        .IR_READY(ready[0]), .S(s_o[0]), .EN(en[0]), .BUSY(busy[0]),
        .DONE(done[0]), .HALTED(halted[0])
    );
    opcode_sequencer #(.DATA_W(8), .OPC_LSB(5), .EXEC_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst), .IR_IN(ir_in), .IR_VALID(ir_valid),
        .IR_READY(ready[1]), .S(s_o[1]), .EN(en[1]), .BUSY(busy[1]),
        .DONE(done[1]), .HALTED(halted[1])
    );
    opcode_sequencer #(.DATA_W(8), .OPC_LSB(5), .EXEC_CYCLES(8)) u_dut8 (
        .CLK(clk), .RST(rst), .IR_IN(ir_in), .IR_VALID(ir_valid),
        .IR_READY(ready[2]), .S(s_o[2]), .EN(en[2]), .BUSY(busy[2]),
        .DONE(done[2]), .HALTED(halted[2])
    );

    // Reference: each instance is described by the opcode last accepted and
    // how many cycles have elapsed since that acceptance edge.
    int         n_cyc [3] = '{4, 1, 8};
    bit         have  [3];
    int         ph    [3];
    logic [2:0] mopc  [3];

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_no = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s[N=%0d] cycle=%0d observed=%0h expected=%0h",
                     tag, n_cyc[k], cycle_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            have[k] = 1'b0;
            ph[k]   = 0;
            mopc[k] = 3'b000;
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic do_cycle(input logic r, input logic v, input logic [7:0] ir,
                            input bit chk);
        logic e_ready [3];
        logic e_en, e_busy, e_done, e_halt;
        rst = r; ir_valid = v; ir_in = ir;
        #2;
        for (int k = 0; k < 3; k++) begin
            e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_halt = 1'b0;
            e_ready[k] = !r;
            if (have[k]) begin
                if (mopc[k] == 3'b111) begin
                    e_busy     = (ph[k] == 1);
                    e_halt     = (ph[k] >= 2);
                    e_ready[k] = 1'b0;
                end else begin
                    e_busy     = (ph[k] >= 1) && (ph[k] <= n_cyc[k] + 1);
                    e_en       = (ph[k] >= 2) && (ph[k] <= n_cyc[k] + 1);
                    e_done     = (ph[k] == n_cyc[k] + 2);
                    e_ready[k] = (ph[k] >= n_cyc[k] + 2) && !r;
                end
            end
            if (chk) begin
                check("IR_READY", k, 32'(ready[k]),  32'(e_ready[k]));
                check("S",        k, 32'(s_o[k]),    32'(mopc[k]));
                check("EN",       k, 32'(en[k]),     32'(e_en));
                check("BUSY",     k, 32'(busy[k]),   32'(e_busy));
                check("DONE",     k, 32'(done[k]),   32'(e_done));
                check("HALTED",   k, 32'(halted[k]), 32'(e_halt));
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                have[k] = 1'b0; ph[k] = 0; mopc[k] = 3'b000;
            end else if (e_ready[k] && v) begin
                have[k] = 1'b1; ph[k] = 1; mopc[k] = ir[7:5];
            end else if (ph[k] < 1000) begin
                ph[k]++;
            end
        end
    endtask

    initial begin
        logic [7:0] rnd_ir;
        logic       rnd_v, rnd_r;
        rst = 1'b1; ir_valid = 1'b0; ir_in = 8'h00;
        @(posedge clk); #1;
        do_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        model_reset();
        // Reset held with a valid instruction present: must be discarded.
        do_cycle(1'b1, 1'b1, 8'hE0, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Single instruction, non-opcode bits set on the idle cycles.
        do_cycle(1'b0, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 8'hFF, 1'b1);

        // Back-to-back with IR_VALID held high.
        do_cycle(1'b0, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 8'hC0, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset landing on the second EN cycle of the default instance.
        do_cycle(1'b0, 1'b1, 8'h7F, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Halt, then later instructions ignored until reset.
        do_cycle(1'b0, 1'b1, 8'hE5, 1'b1);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b1, 8'h40, 1'b1);
        do_cycle(1'b1, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic; halts are rare and resets recover from them.
        for (int i = 0; i < 3000; i++) begin
            rnd_ir = 8'($urandom);
            if (rnd_ir[7:5] == 3'b111 && ($urandom_range(0, 3) != 0))
                rnd_ir[7] = 1'b0;
            rnd_v = ($urandom_range(0, 2) != 0);
            rnd_r = ($urandom_range(0, 39) == 0);
            do_cycle(rnd_r, rnd_v, rnd_ir, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_opcode_sequencer
`default_nettype wire
